// File: rtl/div_share_arbiter.sv
`timescale 1ns/1ps
// Round-robin sharing of one fixed-latency divider core between N_REQ requesters.
// A tag pipeline running beside the core steers each result back to its issuer.
module div_share_arbiter #(
  parameter int N_REQ   = 3,
  parameter int DW      = 12,
  parameter int DIV_LAT = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce_i,
  input  logic [N_REQ-1:0]    req_valid_i,
  output logic [N_REQ-1:0]    req_ready_o,
  input  logic [N_REQ*DW-1:0] req_dividend_i,
  input  logic [N_REQ*DW-1:0] req_divisor_i,
  output logic [DW-1:0]       div_dividend_o,
  output logic [DW-1:0]       div_divisor_o,
  input  logic [DW-1:0]       div_quotient_i,
  input  logic [DW-1:0]       div_fractional_i,
  output logic [N_REQ-1:0]    rsp_valid_o,
  output logic [DW-1:0]       rsp_quotient_o,
  output logic [DW-1:0]       rsp_fractional_o,
  output logic                rsp_dz_o,
  output logic                busy_o
);
  localparam int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW    = IDW + 1;
  localparam int TAG_D = DIV_LAT + 2;

  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic             grant_vld;
  logic [IDW-1:0]   grant_id;
  logic [CW-1:0]    cand_w;
  logic             issue_dz;
  logic [DW-1:0]    div_dividend_q, div_dividend_d;
  logic [DW-1:0]    div_divisor_q, div_divisor_d;
  logic [TAG_D-1:0] tag_vld_q;
  logic [TAG_D-1:0] tag_dz_q;
  logic [IDW-1:0]   tag_id_q [TAG_D];
  logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]    rsp_quotient_q, rsp_quotient_d;
  logic [DW-1:0]    rsp_fractional_q, rsp_fractional_d;
  logic             rsp_dz_q, rsp_dz_d;

  // Grant: first valid requester at or after rr_ptr, modulo N_REQ
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    cand_w    = '0;
    if (ce_i && !rst) begin
      for (int k = 0; k < N_REQ; k++) begin
        cand_w = {1'b0, rr_ptr_q} + CW'(k);
        if (cand_w >= CW'(N_REQ)) cand_w = cand_w - CW'(N_REQ);
        if (!grant_vld && req_valid_i[cand_w[IDW-1:0]]) begin
          grant_vld = 1'b1;
          grant_id  = cand_w[IDW-1:0];
        end
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (grant_vld) req_ready_o[grant_id] = 1'b1;
  end

  // Issue stage: operands to the core, pointer advance
  always_comb begin
    rr_ptr_d       = rr_ptr_q;
    div_dividend_d = div_dividend_q;
    div_divisor_d  = div_divisor_q;
    issue_dz       = 1'b0;
    if (grant_vld) begin
      rr_ptr_d       = (grant_id == IDW'(N_REQ-1)) ? '0 : grant_id + 1'b1;
      div_dividend_d = req_dividend_i[int'(grant_id)*DW +: DW];
      div_divisor_d  = req_divisor_i[int'(grant_id)*DW +: DW];
      issue_dz       = (div_divisor_d == '0);
    end
  end

  // Response stage: tag tail lines up with the core output
  always_comb begin
    rsp_valid_d      = '0;
    rsp_dz_d         = 1'b0;
    rsp_quotient_d   = rsp_quotient_q;
    rsp_fractional_d = rsp_fractional_q;
    if (tag_vld_q[TAG_D-1]) begin
      rsp_valid_d[tag_id_q[TAG_D-1]] = 1'b1;
      rsp_dz_d         = tag_dz_q[TAG_D-1];
      rsp_quotient_d   = tag_dz_q[TAG_D-1] ? '0 : div_quotient_i;
      rsp_fractional_d = tag_dz_q[TAG_D-1] ? '0 : div_fractional_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q         <= '0;
      div_dividend_q   <= '0;
      div_divisor_q    <= '0;
      tag_vld_q        <= '0;
      rsp_valid_q      <= '0;
      rsp_quotient_q   <= '0;
      rsp_fractional_q <= '0;
      rsp_dz_q         <= 1'b0;
    end else begin
      rr_ptr_q         <= rr_ptr_d;
      div_dividend_q   <= div_dividend_d;
      div_divisor_q    <= div_divisor_d;
      tag_vld_q        <= {tag_vld_q[TAG_D-2:0], grant_vld};
      rsp_valid_q      <= rsp_valid_d;
      rsp_quotient_q   <= rsp_quotient_d;
      rsp_fractional_q <= rsp_fractional_d;
      rsp_dz_q         <= rsp_dz_d;
    end
  end

  // Tag payload shifts every clock; the core has no enable to stall it
  always_ff @(posedge clk) begin
    tag_dz_q    <= {tag_dz_q[TAG_D-2:0], issue_dz};
    tag_id_q[0] <= grant_id;
    for (int j = 1; j < TAG_D; j++) tag_id_q[j] <= tag_id_q[j-1];
  end

  assign div_dividend_o   = div_dividend_q;
  assign div_divisor_o    = div_divisor_q;
  assign rsp_valid_o      = rsp_valid_q;
  assign rsp_quotient_o   = rsp_quotient_q;
  assign rsp_fractional_o = rsp_fractional_q;
  assign rsp_dz_o         = rsp_dz_q;
  assign busy_o           = |tag_vld_q;

endmodule

// File: tb/tb_div_share_arbiter.sv
`timescale 1ns/1ps
// Bench for div_share_arbiter: behavioural divider core, negedge monitor with scoreboard queue.
module tb_div_share_arbiter;
  localparam int N_REQ   = 3;
  localparam int DW      = 12;
  localparam int DIV_LAT = 20;
  localparam int RLAT    = DIV_LAT + 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                ce = 1'b0;
  logic [N_REQ-1:0]    req_valid = '0;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ*DW-1:0] req_dividend = '0;
  logic [N_REQ*DW-1:0] req_divisor = '0;
  logic [DW-1:0]       div_dividend, div_divisor, div_quotient, div_fractional;
  logic [N_REQ-1:0]    rsp_valid;
  logic [DW-1:0]       rsp_quotient, rsp_fractional;
  logic                rsp_dz, busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  int issue_cnt = 0;
  int rsp_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  div_share_arbiter #(.N_REQ(N_REQ), .DW(DW), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst(rst), .ce_i(ce),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_dividend_i(req_dividend), .req_divisor_i(req_divisor),
    .div_dividend_o(div_dividend), .div_divisor_o(div_divisor),
    .div_quotient_i(div_quotient), .div_fractional_i(div_fractional),
    .rsp_valid_o(rsp_valid), .rsp_quotient_o(rsp_quotient),
    .rsp_fractional_o(rsp_fractional), .rsp_dz_o(rsp_dz), .busy_o(busy)
  );

  function automatic logic [DW-1:0] ref_q(input logic [DW-1:0] a, input logic [DW-1:0] b);
    if (b == '0) return '1;
    return a / b;
  endfunction

  function automatic logic [DW-1:0] ref_f(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [2*DW-1:0] r;
    if (b == '0) return '1;
    r = {{DW{1'b0}}, a % b} << DW;
    r = r / {{DW{1'b0}}, b};
    return r[DW-1:0];
  endfunction

  // Divider core model: operands sampled at edge k, result valid after edge k+DIV_LAT
  logic [DW-1:0] core_q [DIV_LAT+1];
  logic [DW-1:0] core_f [DIV_LAT+1];
  always @(posedge clk) begin
    for (int j = DIV_LAT; j > 0; j--) begin
      core_q[j] <= core_q[j-1];
      core_f[j] <= core_f[j-1];
    end
    core_q[0] <= ref_q(div_dividend, div_divisor);
    core_f[0] <= ref_f(div_dividend, div_divisor);
  end
  assign div_quotient   = core_q[DIV_LAT];
  assign div_fractional = core_f[DIV_LAT];

  typedef struct {
    int            id;
    logic [DW-1:0] q;
    logic [DW-1:0] f;
    logic          dz;
    int            due;
  } exp_t;
  exp_t sbq[$];

  int               mptr = 0;
  int               wait_c [N_REQ];
  exp_t             e;
  logic [N_REQ-1:0] exp_rv, exp_rdy;
  logic             exp_dz;
  logic [DW-1:0]    exp_q, exp_f, last_q, last_f;
  logic [DW-1:0]    op_a, op_b;
  int               gid;

  always @(negedge clk) begin
    if (mon_en) begin
      exp_rv = '0; exp_dz = 1'b0; exp_q = last_q; exp_f = last_f;
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        e = sbq.pop_front();
        exp_rv[e.id] = 1'b1; exp_dz = e.dz; exp_q = e.q; exp_f = e.f;
      end
      if (rsp_valid !== '0) rsp_cnt++;
      tests++;
      if ({rsp_valid, rsp_dz, rsp_quotient, rsp_fractional} !== {exp_rv, exp_dz, exp_q, exp_f}) begin
        fails++;
        $display("FAIL sb_rsp cyc=%0d got v=%b dz=%b q=%h f=%h want v=%b dz=%b q=%h f=%h",
                 cyc, rsp_valid, rsp_dz, rsp_quotient, rsp_fractional, exp_rv, exp_dz, exp_q, exp_f);
      end
      last_q = exp_q; last_f = exp_f;
      tests++;
      if (busy !== (sbq.size() > 0)) begin
        fails++;
        $display("FAIL sb_busy cyc=%0d got %b want %b", cyc, busy, sbq.size() > 0);
      end
      exp_rdy = '0; gid = 0;
      if (!rst && ce) begin
        for (int k = 0; k < N_REQ; k++) begin
          int c;
          c = (mptr + k) % N_REQ;
          if (exp_rdy == '0 && req_valid[c]) begin
            exp_rdy[c] = 1'b1;
            gid = c;
          end
        end
      end
      tests++;
      if (req_ready !== exp_rdy) begin
        fails++;
        $display("FAIL sb_grant cyc=%0d got %b want %b", cyc, req_ready, exp_rdy);
      end
      if (rst) begin
        sbq.delete(); mptr = 0; last_q = '0; last_f = '0;
        for (int i = 0; i < N_REQ; i++) wait_c[i] = 0;
      end else begin
        if (exp_rdy != '0) begin
          op_a = req_dividend[gid*DW +: DW];
          op_b = req_divisor[gid*DW +: DW];
          e.id = gid; e.dz = (op_b == '0); e.due = cyc + 1 + RLAT;
          e.q = e.dz ? '0 : ref_q(op_a, op_b);
          e.f = e.dz ? '0 : ref_f(op_a, op_b);
          sbq.push_back(e);
          mptr = (gid + 1) % N_REQ;
          issue_cnt++;
        end
        for (int i = 0; i < N_REQ; i++) begin
          if (ce && req_valid[i]) begin
            if (req_ready[i]) begin
              tests++;
              if (wait_c[i] >= N_REQ) begin
                fails++;
                $display("FAIL fairness req=%0d waited %0d cycles, limit %0d", i, wait_c[i] + 1, N_REQ);
              end
              wait_c[i] = 0;
            end else wait_c[i]++;
          end
        end
      end
    end
  end

  task automatic wait_neg(input int target);
    int g = 0;
    do begin @(negedge clk); g++; end while (cyc < target && g < 500);
    tests++;
    if (cyc != target) begin
      fails++;
      $display("FAIL wait_neg reached cyc=%0d want %0d", cyc, target);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ce = 1'b1; req_valid = '1;
    req_dividend = '1; req_divisor = '1;
    repeat (3) @(posedge clk);
    #1; mon_en = 1'b1; last_q = '0; last_f = '0;
    @(negedge clk);
    tests++;
    if ({rsp_valid, rsp_dz, rsp_quotient, rsp_fractional, busy, div_dividend, div_divisor, req_ready} !== '0) begin
      fails++;
      $display("FAIL reset_state v=%b dz=%b q=%h f=%h busy=%b dd=%h dv=%h rdy=%b want all 0",
               rsp_valid, rsp_dz, rsp_quotient, rsp_fractional, busy, div_dividend, div_divisor, req_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0; req_valid = '0; ce = 1'b0;
  endtask

  task automatic test_single();
    int t;
    @(posedge clk); #1;
    req_dividend[0 +: DW] = 12'h300; req_divisor[0 +: DW] = 12'h100;
    req_valid = 3'b001; ce = 1'b1;
    @(negedge clk);
    tests++;
    if (req_ready !== 3'b001) begin fails++; $display("FAIL single_grant got %b want 001", req_ready); end
    @(posedge clk); #1; t = cyc; req_valid = '0;
    wait_neg(t + RLAT - 1);
    tests++;
    if (rsp_valid !== 3'b000) begin fails++; $display("FAIL single_early got %b want 000", rsp_valid); end
    @(negedge clk);
    tests++;
    if ({rsp_valid, rsp_quotient, rsp_fractional} !== {3'b001, 12'h003, 12'h000}) begin
      fails++;
      $display("FAIL single_rsp got v=%b q=%h f=%h want v=001 q=003 f=000", rsp_valid, rsp_quotient, rsp_fractional);
    end
    @(negedge clk);
    tests++;
    if (rsp_valid !== 3'b000) begin fails++; $display("FAIL single_late got %b want 000", rsp_valid); end
  endtask

  task automatic test_rr();
    int c0;
    logic [N_REQ-1:0] want;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    req_dividend = {12'hABC, 12'h7FF, 12'h600};
    req_divisor  = {12'h00F, 12'h003, 12'h200};
    req_valid = 3'b111; ce = 1'b1;
    c0 = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) c0 = cyc;
      want = 3'b001 << (i % 3);
      tests++;
      if (req_ready !== want) begin fails++; $display("FAIL rr_grant%0d got %b want %b", i, req_ready, want); end
      @(posedge clk); #1;
    end
    req_valid = '0;
    wait_neg(c0 + 1 + RLAT);
    for (int i = 0; i < 6; i++) begin
      want = 3'b001 << (i % 3);
      tests++;
      if (rsp_valid !== want) begin fails++; $display("FAIL rr_rsp%0d got %b want %b", i, rsp_valid, want); end
      @(negedge clk);
    end
  endtask

  task automatic test_ce();
    int c0;
    @(posedge clk); #1;
    req_dividend[DW +: DW] = 12'h0FF; req_divisor[DW +: DW] = 12'h011;
    req_valid = 3'b010;
    c0 = 0;
    for (int i = 0; i < 4; i++) begin
      ce = (i % 2 == 0);
      @(negedge clk);
      if (i == 0) c0 = cyc;
      tests++;
      if (req_ready !== (ce ? 3'b010 : 3'b000)) begin
        fails++;
        $display("FAIL ce_grant%0d got %b want %b", i, req_ready, ce ? 3'b010 : 3'b000);
      end
      @(posedge clk); #1;
    end
    req_valid = '0; ce = 1'b0;
    wait_neg(c0 + 1 + RLAT);
    tests++;
    if (rsp_valid !== 3'b010) begin fails++; $display("FAIL ce_rsp0 got %b want 010", rsp_valid); end
    @(negedge clk);
    tests++;
    if (rsp_valid !== 3'b000) begin fails++; $display("FAIL ce_gap got %b want 000", rsp_valid); end
    @(negedge clk);
    tests++;
    if (rsp_valid !== 3'b010) begin fails++; $display("FAIL ce_rsp1 got %b want 010", rsp_valid); end
    ce = 1'b1;
  endtask

  task automatic test_dz();
    int t;
    @(posedge clk); #1;
    req_dividend[2*DW +: DW] = 12'h055; req_divisor[2*DW +: DW] = 12'h000;
    req_valid = 3'b100; ce = 1'b1;
    @(negedge clk);
    tests++;
    if (req_ready !== 3'b100) begin fails++; $display("FAIL dz_grant got %b want 100", req_ready); end
    @(posedge clk); #1; t = cyc;
    req_dividend[0 +: DW] = 12'h123; req_divisor[0 +: DW] = 12'h010;
    req_valid = 3'b001;
    @(negedge clk);
    tests++;
    if (req_ready !== 3'b001) begin fails++; $display("FAIL dz_grant2 got %b want 001", req_ready); end
    @(posedge clk); #1; req_valid = '0;
    wait_neg(t + RLAT);
    tests++;
    if ({rsp_valid, rsp_dz, rsp_quotient, rsp_fractional} !== {3'b100, 1'b1, 12'h000, 12'h000}) begin
      fails++;
      $display("FAIL dz_rsp got v=%b dz=%b q=%h f=%h want v=100 dz=1 q=000 f=000",
               rsp_valid, rsp_dz, rsp_quotient, rsp_fractional);
    end
    @(negedge clk);
    tests++;
    if ({rsp_valid, rsp_dz, rsp_quotient, rsp_fractional} !== {3'b001, 1'b0, 12'h012, 12'h300}) begin
      fails++;
      $display("FAIL dz_next got v=%b dz=%b q=%h f=%h want v=001 dz=0 q=012 f=300",
               rsp_valid, rsp_dz, rsp_quotient, rsp_fractional);
    end
  endtask

  task automatic test_rst_mid();
    @(posedge clk); #1;
    req_dividend[0 +: DW] = 12'h444; req_divisor[0 +: DW] = 12'h022;
    req_valid = 3'b001; ce = 1'b1;
    repeat (4) @(posedge clk);
    #1; req_valid = '0;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got %b want 0", busy); end
    for (int i = 0; i < 2*DIV_LAT; i++) begin
      tests++;
      if (rsp_valid !== 3'b000) begin fails++; $display("FAIL rst_norsp%0d got %b want 000", i, rsp_valid); end
      @(negedge clk);
    end
    @(posedge clk); #1;
    req_dividend = {12'h010, 12'h020, 12'h030};
    req_divisor  = {12'h001, 12'h002, 12'h003};
    req_valid = 3'b111;
    @(negedge clk);
    tests++;
    if (req_ready !== 3'b001) begin fails++; $display("FAIL rst_ptr got %b want 001", req_ready); end
    @(posedge clk); #1; req_valid = '0;
    repeat (RLAT + 2) @(negedge clk);
  endtask

  task automatic test_random();
    logic [N_REQ-1:0] rdy;
    int i0, r0;
    i0 = issue_cnt; r0 = rsp_cnt;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk); rdy = req_ready;
      @(posedge clk); #1;
      ce = ($urandom_range(0, 9) < 8);
      for (int i = 0; i < N_REQ; i++) begin
        if (!req_valid[i] || rdy[i]) begin
          req_valid[i] = ($urandom_range(0, 2) != 0);
          req_dividend[i*DW +: DW] = DW'($urandom);
          if ($urandom_range(0, 15) == 0) req_divisor[i*DW +: DW] = '0;
          else if ($urandom_range(0, 1) == 0) req_divisor[i*DW +: DW] = DW'($urandom_range(1, 300));
          else req_divisor[i*DW +: DW] = DW'($urandom_range(1, 4095));
        end
      end
    end
    req_valid = '0; ce = 1'b1;
    repeat (RLAT + 3) @(negedge clk);
    tests++;
    if (sbq.size() != 0) begin fails++; $display("FAIL rand_drain got %0d pending want 0", sbq.size()); end
    tests++;
    if ((rsp_cnt - r0) != (issue_cnt - i0)) begin
      fails++;
      $display("FAIL rand_count got %0d responses want %0d", rsp_cnt - r0, issue_cnt - i0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr();
    test_ce();
    test_dz();
    test_rst_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog cyc=%0d bench did not finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
